mux_n_1_pipe: RTL and testbench

Parametrised, registered N:1 datapath selector, the successor to the fixed 32-bit 2:1 clocked selectors in the datapath.
- Selects one of NUM_INPUTS words and optionally converts a byte address to a word address (logical right shift by SHIFT_AMT).
- Delivers the result through a 2-entry valid/ready output buffer, so upstream and downstream stages can stall independently.
- Sits between the ALU/immediate/PC sources and their consumers (register write-back, ALU operand, instruction memory address).

---
 rtl/mux_n_1_pipe.sv | 114 +++++++++++
 tb/tb_mux_n_1_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_1_pipe.sv
// Registered N:1 word selector with optional byte-to-word address shift,
// delivered through a 2-entry valid/ready buffer.
module mux_n_1_pipe #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned NUM_INPUTS = 4,
   parameter int unsigned SEL_WIDTH  = 2,
   parameter int unsigned SHIFT_AMT  = 2
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [WIDTH*NUM_INPUTS-1:0]   in_data,
   input  logic [SEL_WIDTH-1:0]          in_sel,
   input  logic                          in_shift,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic                          out_err,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [1:0]                    out_level
);

   localparam int unsigned ENTRY_W = WIDTH + 1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t               state_q;
   state_t               state_nxt;
   logic [ENTRY_W-1:0]   head_q;
   logic [ENTRY_W-1:0]   head_nxt;
   logic [ENTRY_W-1:0]   tail_q;
   logic [ENTRY_W-1:0]   tail_nxt;
   logic [ENTRY_W-1:0]   new_entry;
   logic [WIDTH-1:0]     sel_word;
   logic [WIDTH-1:0]     shifted_word;
   logic                 sel_err;
   logic                 push;
   logic                 pop;

   // Input selection; an unmatched selector yields a zero word flagged as error
   always_comb begin
      sel_word = '0;
      sel_err  = 1'b1;
      for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
         if (in_sel == SEL_WIDTH'(k)) begin
            sel_word = in_data[k*WIDTH +: WIDTH];
            sel_err  = 1'b0;
         end
      end
      shifted_word = in_shift ? (sel_word >> SHIFT_AMT) : sel_word;
      new_entry    = {sel_err, shifted_word};
   end

   // Ready depends only on registered level, never on out_ready
   assign in_ready  = reset_n & (state_q != FULL);
   assign push      = in_valid & in_ready;
   assign pop       = (state_q != EMPTY) & out_ready;

   assign out_valid = (state_q != EMPTY);
   assign out_level = 2'(state_q);
   assign out_data  = head_q[WIDTH-1:0];
   assign out_err   = head_q[WIDTH];

   // Buffer next-state; head holds its value when draining to EMPTY
   always_comb begin
      state_nxt = state_q;
      head_nxt  = head_q;
      tail_nxt  = tail_q;
      unique case (state_q)
         EMPTY: begin
            if (push) begin
               head_nxt  = new_entry;
               state_nxt = ONE;
            end
         end
         ONE: begin
            if (push && pop) begin
               head_nxt = new_entry;
            end else if (push) begin
               tail_nxt  = new_entry;
               state_nxt = FULL;
            end else if (pop) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               head_nxt  = tail_q;
               state_nxt = ONE;
            end
         end
         default: begin
            state_nxt = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_nxt;
         head_q  <= head_nxt;
         tail_q  <= tail_nxt;
      end
   end

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Bench for mux_n_1_pipe: a 4-input and a 3-input instance share stimulus and
// are checked every cycle against a queue-based model plus directed literals.
module tb_mux_n_1_pipe;

   logic         clock;
   logic         reset_n;
   logic [127:0] in_data;
   logic [1:0]   in_sel;
   logic         in_shift;
   logic         in_valid;
   logic         out_ready;

   logic         in_ready4, out_err4, out_valid4;
   logic [31:0]  out_data4;
   logic [1:0]   out_level4;
   logic         in_ready3, out_err3, out_valid3;
   logic [31:0]  out_data3;
   logic [1:0]   out_level3;

   int n_cmp = 0;
   int n_bad = 0;
   bit check_on = 1'b0;

   typedef struct {
      logic [32:0] e4;
      logic [32:0] e3;
   } exp_t;

   exp_t q[$];
   exp_t hold;

   mux_n_1_pipe #(.WIDTH(32), .NUM_INPUTS(4), .SEL_WIDTH(2), .SHIFT_AMT(2)) dut4 (
      .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_sel(in_sel),
      .in_shift(in_shift), .in_valid(in_valid), .in_ready(in_ready4),
      .out_data(out_data4), .out_err(out_err4), .out_valid(out_valid4),
      .out_ready(out_ready), .out_level(out_level4));

   mux_n_1_pipe #(.WIDTH(32), .NUM_INPUTS(3), .SEL_WIDTH(2), .SHIFT_AMT(2)) dut3 (
      .clock(clock), .reset_n(reset_n), .in_data(in_data[95:0]), .in_sel(in_sel),
      .in_shift(in_shift), .in_valid(in_valid), .in_ready(in_ready3),
      .out_data(out_data3), .out_err(out_err3), .out_valid(out_valid3),
      .out_ready(out_ready), .out_level(out_level3));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference value of one request: {err, word}
   function automatic logic [32:0] model_sel(input logic [127:0] d, input logic [1:0] sel,
                                             input logic sh, input int num);
      logic [31:0] v;
      int idx;
      idx = int'(sel);
      if (idx >= num) return {1'b1, 32'h0};
      v = d[idx*32 +: 32];
      if (sh) v = v / 4;
      return {1'b0, v};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: FIFO of at most two entries, ready purely from the pre-edge fill
   always @(posedge clock) begin
      bit do_pop, do_push;
      exp_t e;
      if (!reset_n) begin
         q.delete();
         hold.e4 = '0;
         hold.e3 = '0;
      end else begin
         do_pop  = (q.size() != 0) && out_ready;
         do_push = in_valid && (q.size() < 2);
         e.e4 = model_sel(in_data, in_sel, in_shift, 4);
         e.e3 = model_sel(in_data, in_sel, in_shift, 3);
         if (do_pop) begin
            hold = q[0];
            void'(q.pop_front());
         end
         if (do_push) q.push_back(e);
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clock) begin
      exp_t h;
      if (check_on) begin
         h = (q.size() != 0) ? q[0] : hold;
         chk("in_ready4",  64'(in_ready4),  64'(reset_n && q.size() < 2));
         chk("in_ready3",  64'(in_ready3),  64'(reset_n && q.size() < 2));
         chk("out_valid4", 64'(out_valid4), 64'(q.size() != 0));
         chk("out_valid3", 64'(out_valid3), 64'(q.size() != 0));
         chk("out_level4", 64'(out_level4), 64'(q.size()));
         chk("out_level3", 64'(out_level3), 64'(q.size()));
         chk("head4",      64'({out_err4, out_data4}), 64'(h.e4));
         chk("head3",      64'({out_err3, out_data3}), 64'(h.e3));
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clock);
   endtask

   initial begin
      logic [127:0] lit;
      reset_n   = 1'b0;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      in_shift  = 1'b0;
      out_ready = 1'b1;
      in_data   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

      // Literal pins on the model itself
      lit = {96'h0, 32'h00001008};
      chk("model_addr", 64'(model_sel({lit[95:0], 32'h0}, 2'd1, 1'b1, 4)), 64'h0_00000402);
      lit = {96'h0, 32'hFFFFFFFC};
      chk("model_lsr", 64'(model_sel({lit[95:0], 32'h0}, 2'd1, 1'b1, 4)), 64'h0_3FFFFFFF);
      chk("model_oor", 64'(model_sel(in_data, 2'd3, 1'b1, 3)), 64'h1_00000000);

      // Reset held two cycles with a request pending
      step();
      check_on = 1'b1;
      step();
      at_neg();
      chk("rst_valid", 64'(out_valid4), 64'd0);
      chk("rst_data",  64'(out_data4),  64'd0);
      chk("rst_level", 64'(out_level4), 64'd0);
      chk("rst_ready", 64'(in_ready4),  64'd0);
      in_valid = 1'b0;
      step();
      reset_n = 1'b1;
      at_neg();
      chk("rel_ready", 64'(in_ready4), 64'd1);

      // Basic select
      step();
      in_valid = 1'b1; in_sel = 2'd2; in_shift = 1'b0;
      step();
      in_valid = 1'b0;
      at_neg();
      chk("basic_data",  64'(out_data4),  64'h33333333);
      chk("basic_valid", 64'(out_valid4), 64'd1);
      chk("basic_err",   64'(out_err4),   64'd0);
      step();
      at_neg();
      chk("basic_drain", 64'(out_valid4), 64'd0);

      // Address mode
      step();
      in_data[63:32] = 32'h00001008; in_sel = 2'd1; in_shift = 1'b1; in_valid = 1'b1;
      step();
      in_data[63:32] = 32'hFFFFFFFC;
      at_neg();
      chk("addr_1008", 64'(out_data4), 64'h00000402);
      step();
      in_valid = 1'b0;
      at_neg();
      chk("addr_lsr", 64'(out_data4), 64'h3FFFFFFF);
      step();

      // Backpressure: A, B fill, C waits until level drops
      in_data   = {32'hCCCC0003, 32'h33333333, 32'hBBBB0001, 32'hAAAA0000};
      out_ready = 1'b0; in_shift = 1'b0;
      in_valid = 1'b1; in_sel = 2'd0;
      step();
      in_sel = 2'd1;
      step();
      in_sel = 2'd3;
      at_neg();
      chk("full_level", 64'(out_level4), 64'd2);
      chk("full_ready", 64'(in_ready4),  64'd0);
      chk("full_head",  64'(out_data4),  64'hAAAA0000);
      step();
      at_neg();
      chk("full_hold", 64'(out_level4), 64'd2);
      out_ready = 1'b1;
      step();
      at_neg();
      chk("drain_b",   64'(out_data4),  64'hBBBB0001);
      chk("drain_lvl", 64'(out_level4), 64'd1);
      step();
      in_valid = 1'b0;
      at_neg();
      chk("drain_c",   64'(out_data4),  64'hCCCC0003);
      chk("drain_c3",  64'({out_err3, out_data3}), 64'h1_00000000);
      step();
      at_neg();
      chk("drain_end", 64'(out_valid4), 64'd0);

      // Out of range on the 3-input instance with shift
      in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      in_valid = 1'b1; in_sel = 2'd3; in_shift = 1'b1;
      step();
      in_valid = 1'b0;
      at_neg();
      chk("oor_data3", 64'(out_data3), 64'd0);
      chk("oor_err3",  64'(out_err3),  64'd1);
      chk("oor_data4", 64'(out_data4), 64'h11111111);
      step();

      // Reset while full discards both entries
      out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0; in_shift = 1'b0;
      step();
      step();
      in_valid = 1'b0;
      at_neg();
      chk("pre_rst_lvl", 64'(out_level4), 64'd2);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      out_ready = 1'b1;
      at_neg();
      chk("post_rst_lvl", 64'(out_level4), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         at_neg();
         chk("no_stale", 64'(out_valid4), 64'd0);
      end

      // Randomised traffic with toggling backpressure
      for (int i = 0; i < 400; i++) begin
         step();
         in_valid  = 1'($urandom_range(0, 3) != 0);
         out_ready = 1'($urandom_range(0, 1));
         in_sel    = 2'($urandom_range(0, 3));
         in_shift  = 1'($urandom_range(0, 1));
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         if (i == 350) reset_n = 1'b0;
         if (i == 352) reset_n = 1'b1;
      end
      step();
      at_neg();
      check_on = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
